// File: rtl/alu_commit_sched.sv
// Commit-port scheduler for one ALU block: sticky round-robin arbitration with a
// burst limit, a one-stage registered output buffer and a saturating stall counter.
module alu_commit_sched #(
  parameter int NUM_INPUTS = 2,
  parameter int DATAW      = 64,
  parameter int MAX_GRANTS = 4,
  parameter int PERF_W     = 32,
  localparam int SELW      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_INPUTS-1:0]       valid_in,
  input  logic [NUM_INPUTS*DATAW-1:0] data_in,
  output logic [NUM_INPUTS-1:0]       ready_in,
  output logic                        valid_out,
  output logic [DATAW-1:0]            data_out,
  output logic [SELW-1:0]             sel_out,
  input  logic                        ready_out,
  output logic [PERF_W-1:0]           stall_cnt
);

  localparam int RUNW = $clog2(MAX_GRANTS + 1);
  localparam logic [RUNW-1:0] MAX_RUN = RUNW'(MAX_GRANTS);

  logic                  valid_out_r;
  logic [DATAW-1:0]      data_out_r;
  logic [SELW-1:0]       sel_out_r;
  logic [PERF_W-1:0]     stall_r;
  logic [SELW-1:0]       last_r;
  logic [RUNW-1:0]       run_r;

  logic                  acc_s;
  logic                  any_s;
  logic                  xfer_s;
  logic                  others_s;
  logic                  keep_s;
  logic [SELW-1:0]       idx_s;
  logic [SELW-1:0]       rr_s;
  logic [SELW-1:0]       pick_s;
  logic [DATAW-1:0]      data_pick_s;
  logic [NUM_INPUTS-1:0] ready_s;

  // Arbitration: stay on the last winner until its burst budget runs out while
  // someone else waits, otherwise scan circularly starting after the last winner.
  always_comb begin
    acc_s    = ~valid_out_r | ready_out;
    any_s    = |valid_in;
    xfer_s   = acc_s & any_s;
    others_s = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      others_s = others_s | (valid_in[i] & (SELW'(i) != last_r));
    end
    keep_s = valid_in[last_r] & ((run_r < MAX_RUN) | ~others_s);
    idx_s  = last_r;
    rr_s   = last_r;
    // Descending scan so the nearest successor of last_r wins.
    for (int k = NUM_INPUTS - 1; k >= 1; k--) begin
      idx_s = SELW'((int'(last_r) + k) % NUM_INPUTS);
      if (valid_in[idx_s]) begin
        rr_s = idx_s;
      end else begin
        rr_s = rr_s;
      end
    end
    pick_s = keep_s ? last_r : rr_s;
    data_pick_s = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (pick_s == SELW'(i)) begin
        data_pick_s = data_in[i*DATAW +: DATAW];
      end else begin
        data_pick_s = data_pick_s;
      end
    end
    for (int i = 0; i < NUM_INPUTS; i++) begin
      ready_s[i] = xfer_s & reset & (pick_s == SELW'(i));
    end
  end

  // Output buffer, arbitration history and back-pressure counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_out_r <= 1'b0;
      data_out_r  <= '0;
      sel_out_r   <= '0;
      stall_r     <= '0;
      last_r      <= '0;
      run_r       <= '0;
    end else begin
      if (xfer_s) begin
        valid_out_r <= 1'b1;
        data_out_r  <= data_pick_s;
        sel_out_r   <= pick_s;
        if (pick_s == last_r) begin
          if (run_r < MAX_RUN) begin
            run_r <= run_r + RUNW'(1);
          end
        end else begin
          run_r  <= RUNW'(1);
          last_r <= pick_s;
        end
      end else if (acc_s) begin
        valid_out_r <= 1'b0;
      end
      if (valid_out_r & ~ready_out & ~&stall_r) begin
        stall_r <= stall_r + PERF_W'(1);
      end
    end
  end

  assign ready_in  = ready_s;
  assign valid_out = valid_out_r;
  assign data_out  = data_out_r;
  assign sel_out   = sel_out_r;
  assign stall_cnt = stall_r;

endmodule

// File: tb/tb_alu_commit_sched.sv
// Self-checking bench for alu_commit_sched: directed steps plus a long random
// run against a rule-level reference model and per-producer scoreboard.
module tb_alu_commit_sched;

  localparam int N  = 2;
  localparam int DW = 64;
  localparam int MG = 4;
  localparam int PW = 32;

  logic            clk;
  logic            reset;
  logic [N-1:0]    valid_in;
  logic [N*DW-1:0] data_in;
  logic [N-1:0]    ready_in;
  logic            valid_out;
  logic [DW-1:0]   data_out;
  logic [0:0]      sel_out;
  logic            ready_out;
  logic [PW-1:0]   stall_cnt;

  alu_commit_sched #(.NUM_INPUTS(N), .DATAW(DW), .MAX_GRANTS(MG), .PERF_W(PW)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
    .ready_in(ready_in), .valid_out(valid_out), .data_out(data_out),
    .sel_out(sel_out), .ready_out(ready_out), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // reference model state
  int           m_last, m_run, m_sel;
  bit           m_vout;
  logic [63:0]  m_dout;
  logic [31:0]  m_stall;
  int           prod_seq [N];
  int           exp_seq  [N];
  int           wait_cnt [N];
  bit           sb_en;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [63:0] payload(input int p);
    return {32'(p), 32'(prod_seq[p])};
  endfunction

  function automatic int ref_pick(input logic [N-1:0] v);
    int others;
    others = 0;
    for (int i = 0; i < N; i++) if (i != m_last && v[i]) others++;
    if (v[m_last] && (m_run < MG || others == 0)) return m_last;
    for (int k = 1; k < N; k++) if (v[(m_last + k) % N]) return (m_last + k) % N;
    return m_last;
  endfunction

  task automatic refresh_data();
    data_in = {payload(1), payload(0)};
  endtask

  task automatic drive(input logic [N-1:0] v, input logic r);
    valid_in  = v;
    ready_out = r;
    refresh_data();
  endtask

  // one clock: check against model before the edge, advance model after it
  task automatic tick();
    bit acc, anyv, xfer, rst_v, r_v, v_v;
    int pick;
    logic [63:0] pd;
    logic [N-1:0] exp_ready;
    #1;
    acc   = !m_vout || ready_out;
    anyv  = (valid_in != 2'b00);
    pick  = ref_pick(valid_in);
    rst_v = reset;
    xfer  = rst_v && acc && anyv;
    exp_ready = xfer ? (2'(1) << pick) : 2'b00;
    chk("ready_in", 64'(ready_in), 64'(exp_ready));
    chk("valid_out", 64'(valid_out), 64'(m_vout));
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    if (m_vout) begin
      chk("data_out", data_out, m_dout);
      chk("sel_out", 64'(sel_out), 64'(m_sel));
    end
    if (sb_en && m_vout && ready_out) begin
      chk("sb_order", data_out, {32'(m_sel), 32'(exp_seq[m_sel])});
      exp_seq[m_sel]++;
    end
    if (sb_en && rst_v) begin
      for (int p = 0; p < N; p++) begin
        if (!valid_in[p] || (xfer && pick == p)) wait_cnt[p] = 0;
        else if (xfer) begin
          wait_cnt[p]++;
          chk("wait_bound", 64'(wait_cnt[p] <= MG*(N-1)), 64'd1);
        end
      end
    end
    pd  = payload(pick);
    r_v = ready_out;
    v_v = m_vout;
    @(posedge clk);
    if (!rst_v) begin
      m_vout = 1'b0; m_dout = 64'd0; m_sel = 0; m_stall = 32'd0; m_last = 0; m_run = 0;
    end else begin
      if (v_v && !r_v && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (acc) begin
        if (anyv) begin
          m_vout = 1'b1; m_dout = pd; m_sel = pick;
          if (pick == m_last) m_run = (m_run + 1 > MG) ? MG : m_run + 1;
          else begin m_run = 1; m_last = pick; end
          prod_seq[pick]++;
        end else m_vout = 1'b0;
      end
    end
    @(negedge clk);
    refresh_data();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    logic [63:0] held;
    for (int p = 0; p < N; p++) begin prod_seq[p] = 0; exp_seq[p] = 0; wait_cnt[p] = 0; end
    m_last = 0; m_run = 0; m_sel = 0; m_vout = 1'b0; m_dout = 64'd0; m_stall = 32'd0;
    sb_en = 1'b0;
    reset = 1'b0;
    drive(2'b11, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);

    // 1. reset hold with both producers valid, then release
    repeat (3) tick();
    chk("t1_ready_in", 64'(ready_in), 64'd0);
    chk("t1_valid_out", 64'(valid_out), 64'd0);
    chk("t1_stall", 64'(stall_cnt), 64'd0);
    reset = 1'b1;
    tick();
    chk("t1_rel_valid", 64'(valid_out), 64'd1);
    chk("t1_rel_sel", 64'(sel_out), 64'd0);

    // 2. burst limit: both valid, four grants each in turn
    do_reset();
    drive(2'b11, 1'b1);
    for (int k = 0; k < 16; k++) begin
      tick();
      chk("t2_sel", 64'(sel_out), 64'((k / 4) % 2));
    end

    // 3. lone requester keeps the port with no bubbles
    do_reset();
    drive(2'b10, 1'b1);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t3_valid", 64'(valid_out), 64'd1);
      chk("t3_sel", 64'(sel_out), 64'd1);
    end

    // 4. back-pressure for 7 cycles, then same-cycle drain and reload
    do_reset();
    drive(2'b01, 1'b1);
    tick();
    held = {32'd0, 32'(prod_seq[0] - 1)};
    drive(2'b11, 1'b0);
    for (int k = 0; k < 7; k++) begin
      tick();
      chk("t4_ready_in", 64'(ready_in), 64'd0);
      chk("t4_hold", data_out, held);
    end
    chk("t4_stall7", 64'(stall_cnt), 64'd7);
    drive(2'b11, 1'b1);
    tick();
    chk("t4_reload_valid", 64'(valid_out), 64'd1);
    chk("t4_reload_data", data_out, {32'd0, 32'(prod_seq[0] - 1)});
    chk("t4_stall_hold", 64'(stall_cnt), 64'd7);

    // 6. reset while stalled drops the held result and clears history
    drive(2'b10, 1'b1);
    tick();
    drive(2'b11, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("t6_valid", 64'(valid_out), 64'd0);
    chk("t6_stall", 64'(stall_cnt), 64'd0);
    drive(2'b00, 1'b1);
    tick();
    chk("t6_no_deliver", 64'(valid_out), 64'd0);
    drive(2'b11, 1'b1);
    tick();
    chk("t6_last0", 64'(sel_out), 64'd0);

    // 5. random traffic with scoreboard and fairness bound
    do_reset();
    for (int p = 0; p < N; p++) begin exp_seq[p] = prod_seq[p]; wait_cnt[p] = 0; end
    sb_en = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      drive(2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
      tick();
    end
    drive(2'b00, 1'b1);
    repeat (3) tick();
    for (int p = 0; p < N; p++) chk("t5_no_loss", 64'(exp_seq[p]), 64'(prod_seq[p]));
    sb_en = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
